// File: rtl/unit_out_arbiter_pkg.sv
// Shared definitions for the unit output arbiter: FSM encodings, tag marker
// and header length field position.
package unit_out_arbiter_pkg;

    localparam int N_UNITS_DEF       = 8;
    localparam int WIDTH_DEF         = 16;
    localparam int MAX_PKT_WORDS_DEF = 32;

    localparam logic [7:0] TAG_MARK = 8'hA5;

    // Body length lives in the low byte of the unit header word.
    localparam int LEN_LSB = 0;
    localparam int LEN_MSB = 7;
    localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TAG  = 3'd1,
        ST_HDR  = 3'd2,
        ST_BODY = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/unit_out_arbiter_if.sv
// Unit read ports plus downstream FIFO write port of the unit output arbiter.
interface unit_out_arbiter_if
    import unit_out_arbiter_pkg::*;
#(
    parameter int N_UNITS = N_UNITS_DEF,
    parameter int WIDTH   = WIDTH_DEF
) ();

    logic [WIDTH*N_UNITS-1:0] unit_dout;
    logic [N_UNITS-1:0]       unit_empty;
    logic [N_UNITS-1:0]       unit_rd_en;
    logic [WIDTH-1:0]         dout;
    logic                     wr_en;
    logic                     full;
    logic                     busy;
    logic                     err;

    modport master (
        input  unit_dout, unit_empty, full,
        output unit_rd_en, dout, wr_en, busy, err
    );

    modport slave (
        output unit_dout, unit_empty, full,
        input  unit_rd_en, dout, wr_en, busy, err
    );

endinterface

// File: rtl/unit_out_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest set request index strictly after
// ptr, wrapping to the lowest set index overall.
module unit_out_arbiter_rr_pick
    import unit_out_arbiter_pkg::*;
#(
    parameter int N     = N_UNITS_DEF,
    parameter int IDX_W = idx_bits(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    logic [N-1:0] gt_mask_s;
    logic [N-1:0] hi_req_s;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [N-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            r = v[i] ? IDX_W'(i) : r;
        end
        return r;
    endfunction

    // Requests above the pointer take precedence over the wrapped ones.
    assign gt_mask_s = ({N{1'b1}} << ptr) << 1'b1;
    assign hi_req_s  = req & gt_mask_s;
    assign grant     = (|hi_req_s) ? lowest_set(hi_req_s) : lowest_set(req);
    assign valid     = |req;

endmodule

// File: rtl/unit_out_arbiter.sv
// Round-robin drain of whole unit packets into one output FIFO, each packet
// prefixed with a tag word. UNIT_OUT_CHECKSUM_EN appends an XOR checksum word.
module unit_out_arbiter
    import unit_out_arbiter_pkg::*;
#(
    parameter int N_UNITS       = N_UNITS_DEF,
    parameter int WIDTH         = WIDTH_DEF,
    parameter int MAX_PKT_WORDS = MAX_PKT_WORDS_DEF
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               srst,
    unit_out_arbiter_if.master bus
);

    localparam int IDX_W = idx_bits(N_UNITS);

`ifdef UNIT_OUT_CHECKSUM_EN
    localparam state_t ST_DONE = ST_CSUM;
`else
    localparam state_t ST_DONE = ST_IDLE;
`endif

    state_t             state_r, state_n_s;
    logic [IDX_W-1:0]   sel_r, sel_n_s;
    logic [IDX_W-1:0]   rr_r, rr_n_s;
    logic [LEN_W-1:0]   cnt_r, cnt_n_s;
    logic               err_r, err_n_s;

    logic [IDX_W-1:0]   pick_s;
    logic               pick_valid_s;
    logic [N_UNITS-1:0] req_s;
    logic [N_UNITS-1:0] sel_onehot_s;
    logic [WIDTH-1:0]   unit_word_s;
    logic [WIDTH-1:0]   tag_s;
    logic [LEN_W-1:0]   len_s;
    logic               too_long_s;
    logic               xfer_s;

    logic [N_UNITS-1:0] rd_en_s;
    logic [WIDTH-1:0]   dout_s;
    logic               wr_en_s;

`ifdef UNIT_OUT_CHECKSUM_EN
    logic [WIDTH-1:0]   csum_r, csum_n_s;
`endif

    assign req_s = ~bus.unit_empty;

    unit_out_arbiter_rr_pick #(
        .N     (N_UNITS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req_s),
        .ptr   (rr_r),
        .grant (pick_s),
        .valid (pick_valid_s)
    );

    assign unit_word_s  = bus.unit_dout[WIDTH*sel_r +: WIDTH];
    assign sel_onehot_s = N_UNITS'(1'b1) << sel_r;
    assign len_s        = unit_word_s[LEN_MSB:LEN_LSB];
    assign too_long_s   = (len_s > LEN_W'(MAX_PKT_WORDS));
    // A unit word moves only when the selected unit has data and the FIFO has room.
    assign xfer_s       = !bus.full && !bus.unit_empty[sel_r];

    // Tag word: marker byte on top, granted unit index in the low bits.
    always_comb begin
        tag_s                   = '0;
        tag_s[WIDTH-1 -: 8]     = TAG_MARK;
        tag_s[IDX_W-1:0]        = sel_r;
    end

    // Next-state and strobe decode; strobes are never raised during a stall.
    always_comb begin
        state_n_s = state_r;
        sel_n_s   = sel_r;
        rr_n_s    = rr_r;
        cnt_n_s   = cnt_r;
        err_n_s   = err_r;
        rd_en_s   = '0;
        wr_en_s   = 1'b0;
        dout_s    = '0;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    sel_n_s   = pick_s;
                    rr_n_s    = pick_s;
                    state_n_s = ST_TAG;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_TAG: begin
                if (!bus.full) begin
                    wr_en_s   = 1'b1;
                    dout_s    = tag_s;
                    state_n_s = ST_HDR;
                end else begin
                    state_n_s = ST_TAG;
                end
            end
            ST_HDR: begin
                if (xfer_s) begin
                    rd_en_s = sel_onehot_s;
                    wr_en_s = 1'b1;
                    dout_s  = unit_word_s;
                    cnt_n_s = len_s;
                    if (len_s == '0) begin
                        state_n_s = ST_DONE;
                    end else begin
                        // Oversized packets are flagged but still forwarded intact.
                        err_n_s   = err_r | too_long_s;
                        state_n_s = ST_BODY;
                    end
                end else begin
                    state_n_s = ST_HDR;
                end
            end
            ST_BODY: begin
                if (xfer_s) begin
                    rd_en_s = sel_onehot_s;
                    wr_en_s = 1'b1;
                    dout_s  = unit_word_s;
                    cnt_n_s = cnt_r - LEN_W'(1'b1);
                    if (cnt_r == LEN_W'(1'b1)) begin
                        state_n_s = ST_DONE;
                    end else begin
                        state_n_s = ST_BODY;
                    end
                end else begin
                    state_n_s = ST_BODY;
                end
            end
`ifdef UNIT_OUT_CHECKSUM_EN
            ST_CSUM: begin
                if (!bus.full) begin
                    wr_en_s   = 1'b1;
                    dout_s    = csum_r;
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_CSUM;
                end
            end
`endif
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

`ifdef UNIT_OUT_CHECKSUM_EN
    // Running XOR over every word written for the current packet.
    always_comb begin
        if (state_r == ST_IDLE) begin
            csum_n_s = '0;
        end else if (wr_en_s && (state_r != ST_CSUM)) begin
            csum_n_s = csum_r ^ dout_s;
        end else begin
            csum_n_s = csum_r;
        end
    end
`endif

    // State registers; rr_r starts at the last unit so unit 0 is granted first.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_IDLE;
            sel_r   <= '0;
            rr_r    <= IDX_W'(N_UNITS - 1);
            cnt_r   <= '0;
            err_r   <= 1'b0;
`ifdef UNIT_OUT_CHECKSUM_EN
            csum_r  <= '0;
`endif
        end else if (srst) begin
            state_r <= ST_IDLE;
            sel_r   <= '0;
            rr_r    <= IDX_W'(N_UNITS - 1);
            cnt_r   <= '0;
            err_r   <= 1'b0;
`ifdef UNIT_OUT_CHECKSUM_EN
            csum_r  <= '0;
`endif
        end else begin
            state_r <= state_n_s;
            sel_r   <= sel_n_s;
            rr_r    <= rr_n_s;
            cnt_r   <= cnt_n_s;
            err_r   <= err_n_s;
`ifdef UNIT_OUT_CHECKSUM_EN
            csum_r  <= csum_n_s;
`endif
        end
    end

    assign bus.unit_rd_en = rd_en_s;
    assign bus.wr_en      = wr_en_s;
    assign bus.dout       = dout_s;
    assign bus.busy       = (state_r != ST_IDLE);
    assign bus.err        = err_r;

endmodule
